// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the ID stage: opcodes, next-PC encodings,
// Tuse constants and the instruction decoder used by id_stage.
package id_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_JR   = 6'b001000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;

  localparam logic [1:0] PC_ADD4 = 2'b00;
  localparam logic [1:0] PC_NPC  = 2'b01;
  localparam logic [1:0] PC_RFV1 = 2'b10;

  // A Tuse of 3 can never be below any 2-bit Tnew, so unused operands never stall.
  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef enum logic [1:0] {
    FWD_RF   = 2'd0,
    FWD_E    = 2'd1,
    FWD_M    = 2'd2,
    FWD_ZERO = 2'd3
  } fwd_sel_e;

  typedef enum logic [3:0] {
    I_NOP, I_BEQ, I_J, I_JAL, I_JR, I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW
  } instr_kind_e;

  typedef struct packed {
    instr_kind_e kind;
    logic [1:0]  pc_sel;
    logic        is_beq;
    logic [1:0]  tuse_rs;
    logic [1:0]  tuse_rt;
  } decode_t;

  function automatic instr_kind_e classify(input logic [31:0] instr);
    instr_kind_e k;
    k = I_NOP;
    case (instr[31:26])
      OP_BEQ: k = I_BEQ;
      OP_J:   k = I_J;
      OP_JAL: k = I_JAL;
      OP_ORI: k = I_ORI;
      OP_LUI: k = I_LUI;
      OP_LW:  k = I_LW;
      OP_SW:  k = I_SW;
      OP_RTYPE: begin
        case (instr[5:0])
          FUNCT_JR:   k = I_JR;
          FUNCT_ADDU: k = I_ADDU;
          FUNCT_SUBU: k = I_SUBU;
          default:    k = I_NOP;
        endcase
      end
      default: k = I_NOP;
    endcase
    return k;
  endfunction

  function automatic decode_t decode(input logic [31:0] instr);
    decode_t d;
    d.kind    = classify(instr);
    d.pc_sel  = PC_ADD4;
    d.is_beq  = 1'b0;
    d.tuse_rs = TUSE_NONE;
    d.tuse_rt = TUSE_NONE;
    case (d.kind)
      I_BEQ: begin
        d.pc_sel  = PC_NPC;
        d.is_beq  = 1'b1;
        d.tuse_rs = 2'd0;
        d.tuse_rt = 2'd0;
      end
      I_J, I_JAL: d.pc_sel = PC_NPC;
      I_JR: begin
        d.pc_sel  = PC_RFV1;
        d.tuse_rs = 2'd0;
      end
      I_ADDU, I_SUBU: begin
        d.tuse_rs = 2'd1;
        d.tuse_rt = 2'd1;
      end
      I_ORI, I_LW: d.tuse_rs = 2'd1;
      I_SW: begin
        d.tuse_rs = 2'd1;
        d.tuse_rt = 2'd2;
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                          input logic [31:0] rf_val,
                                          input logic [31:0] e_val,
                                          input logic [31:0] m_val);
    logic [31:0] v;
    case (sel)
      FWD_E:    v = e_val;
      FWD_M:    v = m_val;
      FWD_ZERO: v = 32'h0;
      default:  v = rf_val;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/id_stage_hazard_unit.sv
// Stall detection (Tuse vs Tnew) and forward-source selection for the
// rs/rt operands of the D-stage instruction.
module id_stage_hazard_unit
  import id_stage_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [1:0] tuse_rs,
  input  logic [1:0] tuse_rt,
  input  logic       we_e,
  input  logic [4:0] waddr_e,
  input  logic [1:0] tnew_e,
  input  logic       we_m,
  input  logic [4:0] waddr_m,
  input  logic [1:0] tnew_m,
  output logic       stall,
  output logic [1:0] fwd_rs,
  output logic [1:0] fwd_rt
);

  logic hit_rs_e, hit_rs_m, hit_rt_e, hit_rt_m;

  // $0 is hard-wired, so a pending write to it never creates a dependency.
  assign hit_rs_e = (rs != 5'd0) && we_e && (waddr_e == rs);
  assign hit_rs_m = (rs != 5'd0) && we_m && (waddr_m == rs);
  assign hit_rt_e = (rt != 5'd0) && we_e && (waddr_e == rt);
  assign hit_rt_m = (rt != 5'd0) && we_m && (waddr_m == rt);

  assign stall = (hit_rs_e && (tuse_rs < tnew_e)) ||
                 (hit_rs_m && (tuse_rs < tnew_m)) ||
                 (hit_rt_e && (tuse_rt < tnew_e)) ||
                 (hit_rt_m && (tuse_rt < tnew_m));

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    fwd_rs = FWD_RF;
    if (rs == 5'd0)                      fwd_rs = FWD_ZERO;
    else if (hit_rs_e && tnew_e == 2'd0) fwd_rs = FWD_E;
    else if (hit_rs_m && tnew_m == 2'd0) fwd_rs = FWD_M;
  end

  always_comb begin
    fwd_rt = FWD_RF;
    if (rt == 5'd0)                      fwd_rt = FWD_ZERO;
    else if (hit_rt_e && tnew_e == 2'd0) fwd_rt = FWD_E;
    else if (hit_rt_m && tnew_m == 2'd0) fwd_rt = FWD_M;
  end

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: IF/ID register, next-PC control decode, branch/jr
// operand forwarding and the Tuse/Tnew pipeline stall.
module id_stage
  import id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC8   = 32'h0000_3008,
  parameter int          STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            instr_f,
  input  logic [31:0]            pc8_f,
  input  logic [31:0]            rf_rd1,
  input  logic [31:0]            rf_rd2,
  input  logic                   we_e,
  input  logic [4:0]             waddr_e,
  input  logic [31:0]            wdata_e,
  input  logic [1:0]             tnew_e,
  input  logic                   we_m,
  input  logic [4:0]             waddr_m,
  input  logic [31:0]            wdata_m,
  input  logic [1:0]             tnew_m,
  output logic [4:0]             rf_ra1,
  output logic [4:0]             rf_ra2,
  output logic [1:0]             pc_sel,
  output logic [15:0]            i16,
  output logic [25:0]            i26,
  output logic [31:0]            pc_temp,
  output logic                   co,
  output logic                   beq,
  output logic                   stall,
  output logic                   clr_e,
  output logic [31:0]            instr_d,
  output logic [31:0]            pc8_d,
  output logic [31:0]            rs_val_d,
  output logic [31:0]            rt_val_d,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  decode_t    dec;
  logic [1:0] fwd_rs, fwd_rt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_d   <= 32'h0;
      pc8_d     <= RESET_PC8;
      stall_cnt <= '0;
    end else begin
      // No flush path: the branch delay slot always executes.
      if (!stall) begin
        instr_d <= instr_f;
        pc8_d   <= pc8_f;
      end
      if (stall && (stall_cnt != {STALL_CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign dec    = decode(instr_d);
  assign rf_ra1 = instr_d[25:21];
  assign rf_ra2 = instr_d[20:16];
  assign i16    = instr_d[15:0];
  assign i26    = instr_d[25:0];
  assign pc_sel = dec.pc_sel;
  assign beq    = dec.is_beq;

  id_stage_hazard_unit u_hazard (
    .rs      (instr_d[25:21]),
    .rt      (instr_d[20:16]),
    .tuse_rs (dec.tuse_rs),
    .tuse_rt (dec.tuse_rt),
    .we_e    (we_e),
    .waddr_e (waddr_e),
    .tnew_e  (tnew_e),
    .we_m    (we_m),
    .waddr_m (waddr_m),
    .tnew_m  (tnew_m),
    .stall   (stall),
    .fwd_rs  (fwd_rs),
    .fwd_rt  (fwd_rt)
  );

  assign rs_val_d = fwd_mux(fwd_rs, rf_rd1, wdata_e, wdata_m);
  assign rt_val_d = fwd_mux(fwd_rt, rf_rd2, wdata_e, wdata_m);
  assign pc_temp  = rs_val_d;
  assign co       = (rs_val_d == rt_val_d);
  assign clr_e    = stall;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expectations are queued as stimulus is driven
// and drained against the DUT once its outputs have settled.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_f, pc8_f, rf_rd1, rf_rd2, wdata_e, wdata_m;
  logic        we_e, we_m;
  logic [4:0]  waddr_e, waddr_m;
  logic [1:0]  tnew_e, tnew_m;
  logic [4:0]  rf_ra1, rf_ra2;
  logic [1:0]  pc_sel;
  logic [15:0] i16;
  logic [25:0] i26;
  logic [31:0] pc_temp, instr_d, pc8_d, rs_val_d, rt_val_d;
  logic        co, beq, stall, clr_e;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  always #50 clk = ~clk;

  id_stage dut (
    .clk(clk), .reset(reset), .instr_f(instr_f), .pc8_f(pc8_f),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .we_e(we_e), .waddr_e(waddr_e), .wdata_e(wdata_e), .tnew_e(tnew_e),
    .we_m(we_m), .waddr_m(waddr_m), .wdata_m(wdata_m), .tnew_m(tnew_m),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .pc_sel(pc_sel), .i16(i16), .i26(i26),
    .pc_temp(pc_temp), .co(co), .beq(beq), .stall(stall), .clr_e(clr_e),
    .instr_d(instr_d), .pc8_d(pc8_d), .rs_val_d(rs_val_d), .rt_val_d(rt_val_d),
    .stall_cnt(stall_cnt)
  );

  function automatic logic [31:0] observe(input string tag);
    case (tag)
      "instr_d":   return instr_d;
      "pc8_d":     return pc8_d;
      "stall":     return {31'h0, stall};
      "clr_e":     return {31'h0, clr_e};
      "pc_sel":    return {30'h0, pc_sel};
      "beq":       return {31'h0, beq};
      "co":        return {31'h0, co};
      "i16":       return {16'h0, i16};
      "i26":       return {6'h0, i26};
      "rf_ra1":    return {27'h0, rf_ra1};
      "rf_ra2":    return {27'h0, rf_ra2};
      "pc_temp":   return pc_temp;
      "rs_val_d":  return rs_val_d;
      "rt_val_d":  return rt_val_d;
      "stall_cnt": return {16'h0, stall_cnt};
      default:     return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.tag), e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hazards();
    we_e = 1'b0; waddr_e = 5'd0; tnew_e = 2'd0; wdata_e = 32'h0;
    we_m = 1'b0; waddr_m = 5'd0; tnew_m = 2'd0; wdata_m = 32'h0;
  endtask

  initial begin
    reset = 1'b1;
    instr_f = 32'hFFFF_FFFF; pc8_f = 32'h0000_1234;
    rf_rd1 = 32'h0; rf_rd2 = 32'h0;
    clear_hazards();
    repeat (2) step();
    expect_val("instr_d", 32'h0);
    expect_val("pc8_d", 32'h0000_3008);
    expect_val("stall_cnt", 32'h0);
    expect_val("stall", 32'h0);
    expect_val("pc_sel", 32'h0);
    drain();

    // ori $1,$0,5 enters IF/ID
    reset = 1'b0;
    instr_f = 32'h3401_0005; pc8_f = 32'h0000_3008;
    step();
    expect_val("instr_d", 32'h3401_0005);
    expect_val("pc8_d", 32'h0000_3008);
    expect_val("stall", 32'h0);
    expect_val("pc_sel", 32'h0);
    expect_val("rf_ra2", 32'h1);
    drain();

    // beq $1,$2,0x10 with equal then unequal operands
    instr_f = 32'h1022_0010; pc8_f = 32'h0000_300C;
    step();
    rf_rd1 = 32'h7; rf_rd2 = 32'h7;
    expect_val("pc_sel", 32'h1);
    expect_val("beq", 32'h1);
    expect_val("co", 32'h1);
    expect_val("i16", 32'h0010);
    expect_val("i26", 32'h0022_0010);
    expect_val("rf_ra1", 32'h1);
    expect_val("rf_ra2", 32'h2);
    drain();
    rf_rd2 = 32'h8;
    expect_val("co", 32'h0);
    expect_val("rt_val_d", 32'h8);
    drain();

    // E-stage producer of $1 not ready: stall two cycles
    we_e = 1'b1; waddr_e = 5'd1; tnew_e = 2'd1;
    expect_val("stall", 32'h1);
    expect_val("clr_e", 32'h1);
    drain();
    instr_f = 32'hDEAD_BEEF; pc8_f = 32'h0000_3010;
    step();
    step();
    expect_val("instr_d", 32'h1022_0010);
    expect_val("pc8_d", 32'h0000_300C);
    expect_val("stall_cnt", 32'h2);
    expect_val("stall", 32'h1);
    drain();

    // M-stage producer of $2: stalls while pending, forwards once ready
    clear_hazards();
    we_m = 1'b1; waddr_m = 5'd2; tnew_m = 2'd1;
    expect_val("stall", 32'h1);
    drain();
    tnew_m = 2'd0; wdata_m = 32'h7;
    expect_val("stall", 32'h0);
    expect_val("rt_val_d", 32'h7);
    expect_val("co", 32'h1);
    drain();

    // jr $31 with E and M both ready: E wins, then M, then register file
    clear_hazards();
    instr_f = 32'h03E0_0008; pc8_f = 32'h0000_3014;
    step();
    rf_rd1 = 32'h0000_1111;
    we_e = 1'b1; waddr_e = 5'd31; tnew_e = 2'd0; wdata_e = 32'h0000_3010;
    we_m = 1'b1; waddr_m = 5'd31; tnew_m = 2'd0; wdata_m = 32'h0000_4000;
    expect_val("pc_sel", 32'h2);
    expect_val("pc_temp", 32'h0000_3010);
    expect_val("beq", 32'h0);
    expect_val("stall", 32'h0);
    drain();
    we_e = 1'b0;
    expect_val("pc_temp", 32'h0000_4000);
    drain();
    we_m = 1'b0;
    expect_val("pc_temp", 32'h0000_1111);
    drain();

    // sw $2,0($1): rt needed late, rs needed at E
    clear_hazards();
    instr_f = 32'hAC22_0000; pc8_f = 32'h0000_3018;
    step();
    we_e = 1'b1; waddr_e = 5'd2; tnew_e = 2'd2;
    expect_val("stall", 32'h0);
    drain();
    waddr_e = 5'd1;
    expect_val("stall", 32'h1);
    expect_val("clr_e", 32'h1);
    drain();
    tnew_e = 2'd1;
    expect_val("stall", 32'h0);
    drain();

    // beq $0,$0 with a pending write to $0
    clear_hazards();
    instr_f = 32'h1000_0000; pc8_f = 32'h0000_301C;
    step();
    rf_rd1 = 32'h5; rf_rd2 = 32'h9;
    we_e = 1'b1; waddr_e = 5'd0; tnew_e = 2'd2; wdata_e = 32'hABCD_0000;
    expect_val("stall", 32'h0);
    expect_val("rs_val_d", 32'h0);
    expect_val("co", 32'h1);
    expect_val("stall_cnt", 32'h2);
    drain();

    // Reset asserted during a stall wins
    clear_hazards();
    instr_f = 32'h1022_0010; pc8_f = 32'h0000_3020;
    step();
    we_e = 1'b1; waddr_e = 5'd2; tnew_e = 2'd2;
    expect_val("stall", 32'h1);
    drain();
    reset = 1'b1;
    step();
    expect_val("instr_d", 32'h0);
    expect_val("pc8_d", 32'h0000_3008);
    expect_val("stall_cnt", 32'h0);
    expect_val("stall", 32'h0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
